// File: rtl/alu_pkg.sv
// alu_pkg: shared class/opcode/flag/state constants for the sequenced ALU
package alu_pkg;
   localparam logic [1:0] SM_MEM = 2'b00, SM_ARITH = 2'b01, SM_LOGIC = 2'b10, SM_FLOW = 2'b11;
   localparam logic [3:0] OP_LDI = 4'd0, OP_LDM = 4'd1, OP_STM = 4'd2;
   localparam logic [3:0] OP_CMP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_ADC = 4'd3, OP_MUL = 4'd4;
   localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_XOR = 4'd2, OP_NOT = 4'd3, OP_SL0 = 4'd4;
   localparam logic [3:0] OP_SL1 = 4'd5, OP_SR0 = 4'd6, OP_SR1 = 4'd7, OP_ROL = 4'd8, OP_ROR = 4'd9;
   localparam logic [3:0] OP_JMP = 4'd0, OP_JNZ = 4'd1, OP_JZ = 4'd2, OP_JNC = 4'd3, OP_JC = 4'd4;
   localparam int FLG_C = 0, FLG_Z = 1, FLG_N = 2, FLG_V = 3;
   localparam logic [0:0] ST_IDLE = 1'b0, ST_MUL = 1'b1;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one partial product per cycle
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   assign done = busy && cnt == CW'(WIDTH);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         cnt    <= '0;
         prod   <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         prod   <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
      end else if (busy) begin
         if (done) busy <= 1'b0;
         else begin
            prod   <= prod + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with flag file, branch resolve and sequential multiply
module alu_seq import alu_pkg::*; #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       sm,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rd,
   output logic             wb_en,
   output logic             br_taken,
   output logic [3:0]       flags,
   output logic             illegal
);
   logic [0:0]         state;
   logic               acc, is_mul, mul_busy, mul_done;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     sum, dif;
   logic [WIDTH-1:0]   res, zv;
   logic               c_n, v_n, upd, wb_n, br_n, ill_n;
   logic [3:0]         fnew, mfl;
   assign in_ready = rst_n && state == ST_IDLE && !mul_busy && (!out_valid || out_ready);
   assign is_mul   = MUL_EN && sm == SM_ARITH && op == OP_MUL;
   assign acc      = in_valid && in_ready;
   assign fnew     = {v_n, zv[WIDTH-1], zv == '0, c_n};
   assign mfl      = {1'b0, prod[WIDTH-1], prod[WIDTH-1:0] == '0, |prod[2*WIDTH-1:WIDTH]};
   always_comb begin
      sum   = {1'b0, rs1} + {1'b0, rs2} + {{WIDTH{1'b0}}, op == OP_ADC && flags[FLG_C]};
      dif   = {1'b0, rs1} - {1'b0, rs2};
      res   = '0;
      zv    = '0;
      c_n   = 1'b0;
      v_n   = 1'b0;
      upd   = 1'b0;
      wb_n  = 1'b0;
      br_n  = 1'b0;
      ill_n = 1'b0;
      case (sm)
         SM_MEM: begin
            ill_n = op > OP_STM;
            res   = ill_n ? '0 : rs2;
            wb_n  = op == OP_LDI || op == OP_LDM;
         end
         SM_ARITH: case (op)
            OP_CMP, OP_SUB: begin
               res  = op == OP_CMP ? rs1 : dif[WIDTH-1:0];
               zv   = dif[WIDTH-1:0];
               c_n  = ~dif[WIDTH];
               v_n  = (rs1[WIDTH-1] != rs2[WIDTH-1]) && (dif[WIDTH-1] != rs1[WIDTH-1]);
               upd  = 1'b1;
               wb_n = op == OP_SUB;
            end
            OP_ADD, OP_ADC: begin
               res  = sum[WIDTH-1:0];
               zv   = sum[WIDTH-1:0];
               c_n  = sum[WIDTH];
               v_n  = (rs1[WIDTH-1] == rs2[WIDTH-1]) && (sum[WIDTH-1] != rs1[WIDTH-1]);
               upd  = 1'b1;
               wb_n = 1'b1;
            end
            OP_MUL:  ill_n = !MUL_EN;
            default: ill_n = 1'b1;
         endcase
         SM_LOGIC: begin
            case (op)
               OP_AND: res = rs1 & rs2;
               OP_OR:  res = rs1 | rs2;
               OP_XOR: res = rs1 ^ rs2;
               OP_NOT: res = ~rs1;
               OP_SL0: {c_n, res} = {rs1, 1'b0};
               OP_SL1: {c_n, res} = {rs1, 1'b1};
               OP_SR0: {res, c_n} = {1'b0, rs1};
               OP_SR1: {res, c_n} = {1'b1, rs1};
               OP_ROL: {c_n, res} = {rs1[WIDTH-1], rs1[WIDTH-2:0], rs1[WIDTH-1]};
               OP_ROR: {res, c_n} = {rs1[0], rs1[WIDTH-1:1], rs1[0]};
               default: ill_n = 1'b1;
            endcase
            zv   = res;
            upd  = !ill_n;
            wb_n = !ill_n;
         end
         default: begin
            ill_n = op > OP_JC;
            res   = ill_n ? '0 : rs2;
            br_n  = !ill_n && (op == OP_JMP || (op == OP_JNZ && !flags[FLG_Z]) ||
                    (op == OP_JZ && flags[FLG_Z]) || (op == OP_JNC && !flags[FLG_C]) ||
                    (op == OP_JC && flags[FLG_C]));
         end
      endcase
   end
   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (acc && is_mul),
      .a     (rs1),
      .b     (rs2),
      .busy  (mul_busy),
      .done  (mul_done),
      .prod  (prod)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         rd        <= '0;
         wb_en     <= 1'b0;
         br_taken  <= 1'b0;
         illegal   <= 1'b0;
         flags     <= '0;
      end else if (mul_done) begin
         state     <= ST_IDLE;
         out_valid <= 1'b1;
         rd        <= prod[WIDTH-1:0];
         wb_en     <= 1'b1;
         br_taken  <= 1'b0;
         illegal   <= 1'b0;
         flags     <= mfl;
      end else if (acc && is_mul) begin
         state     <= ST_MUL;
         out_valid <= 1'b0;
      end else if (acc) begin
         out_valid <= 1'b1;
         rd        <= res;
         wb_en     <= wb_n;
         br_taken  <= br_n;
         illegal   <= ill_n;
         if (upd) flags <= fnew;
      end else if (out_ready) out_valid <= 1'b0;
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq (WIDTH=8)
module tb_alu_seq;
   logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [1:0] sm = 2'b00;
   logic [3:0] op = 4'd0;
   logic [7:0] rs1 = 8'h00, rs2 = 8'h00;
   logic       in_ready, out_valid, wb_en, br_taken, illegal;
   logic [7:0] rd;
   logic [3:0] flags;
   logic       in_ready2, out_valid2, wb_en2, br_taken2, illegal2;
   logic [7:0] rd2;
   logic [3:0] flags2;
   int n = 0, errs = 0;
   always #5 clk = ~clk;
   alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sm(sm), .op(op),
      .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
      .wb_en(wb_en), .br_taken(br_taken), .flags(flags), .illegal(illegal)
   );
   alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut_nomul (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .sm(sm), .op(op),
      .rs1(rs1), .rs2(rs2), .out_valid(out_valid2), .out_ready(out_ready), .rd(rd2),
      .wb_en(wb_en2), .br_taken(br_taken2), .flags(flags2), .illegal(illegal2)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic issue(input logic [1:0] s, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
      sm = s; op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask
   initial begin
      step(); step();
      chk("rst out_valid", out_valid, 0);
      chk("rst rd", rd, 0);
      chk("rst flags", flags, 0);
      chk("rst in_ready", in_ready, 0);
      chk("rst wb/br/ill", {wb_en, br_taken, illegal}, 0);
      rst_n = 1'b1;
      #1;
      chk("post-rst in_ready", in_ready, 1);
      issue(2'b01, 4'd1, 8'hF0, 8'h20);
      chk("add out_valid", out_valid, 1);
      chk("add rd", rd, 8'h10);
      chk("add flags", flags, 4'b0001);
      chk("add wb_en", wb_en, 1);
      issue(2'b01, 4'd3, 8'h01, 8'h01);
      chk("adc rd", rd, 8'h03);
      chk("adc flags", flags, 4'b0000);
      issue(2'b01, 4'd2, 8'h05, 8'h05);
      chk("sub rd", rd, 8'h00);
      chk("sub flags", flags, 4'b0011);
      issue(2'b11, 4'd2, 8'h00, 8'h3C);
      chk("jz br_taken", br_taken, 1);
      chk("jz rd", rd, 8'h3C);
      chk("jz wb_en", wb_en, 0);
      issue(2'b11, 4'd1, 8'h00, 8'h3C);
      chk("jnz br_taken", br_taken, 0);
      issue(2'b01, 4'd0, 8'h7F, 8'h80);
      chk("cmp rd", rd, 8'h7F);
      chk("cmp wb_en", wb_en, 0);
      chk("cmp flags", flags, 4'b1100);
      issue(2'b00, 4'd0, 8'h00, 8'h55);
      chk("ldi rd", rd, 8'h55);
      chk("ldi wb_en", wb_en, 1);
      chk("ldi flags kept", flags, 4'b1100);
      issue(2'b00, 4'd2, 8'h00, 8'hAA);
      chk("stm wb_en", wb_en, 0);
      issue(2'b01, 4'd4, 8'h12, 8'h10);
      for (int i = 0; i < 8; i++) begin
         chk("mul in_ready low", in_ready, 0);
         chk("mul out_valid low", out_valid, 0);
         step();
      end
      chk("mul out_valid at 8", out_valid, 0);
      step();
      chk("mul out_valid at 9", out_valid, 1);
      chk("mul rd", rd, 8'h20);
      chk("mul flags", flags, 4'b0001);
      chk("mul wb_en", wb_en, 1);
      issue(2'b01, 4'd4, 8'h03, 8'h05);
      step(); step(); step();
      rst_n = 1'b0;
      step();
      chk("mulrst out_valid", out_valid, 0);
      chk("mulrst rd", rd, 0);
      chk("mulrst flags", flags, 0);
      chk("mulrst in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("mulrst release in_ready", in_ready, 1);
      repeat (12) step();
      chk("mulrst no result", out_valid, 0);
      out_ready = 1'b0;
      issue(2'b10, 4'd8, 8'h81, 8'h00);
      for (int i = 0; i < 5; i++) begin
         chk("stall out_valid", out_valid, 1);
         chk("stall rd", rd, 8'h03);
         chk("stall flags", flags, 4'b0001);
         chk("stall in_ready", in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("release in_ready", in_ready, 1);
      issue(2'b01, 4'd1, 8'h10, 8'h22);
      chk("release add rd", rd, 8'h32);
      chk("release add out_valid", out_valid, 1);
      issue(2'b01, 4'd2, 8'h00, 8'h01);
      chk("sub borrow rd", rd, 8'hFF);
      chk("sub borrow flags", flags, 4'b0100);
      issue(2'b10, 4'd4, 8'h80, 8'h00);
      chk("sl0 rd", rd, 8'h00);
      chk("sl0 flags", flags, 4'b0011);
      issue(2'b10, 4'd7, 8'h02, 8'h00);
      chk("sr1 rd", rd, 8'h81);
      chk("sr1 flags", flags, 4'b0100);
      issue(2'b10, 4'hF, 8'h12, 8'h34);
      chk("illegal flag", illegal, 1);
      chk("illegal rd", rd, 8'h00);
      chk("illegal wb_en", wb_en, 0);
      chk("illegal flags kept", flags, 4'b0100);
      issue(2'b01, 4'd4, 8'h12, 8'h10);
      chk("nomul out_valid", out_valid2, 1);
      chk("nomul illegal", illegal2, 1);
      chk("nomul rd", rd2, 8'h00);
      chk("withmul busy", in_ready, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n, errs);
      $finish;
   end
endmodule
